down_counter_load: RTL
======================

Name: down_counter_load

Overview:
- Synchronous, loadable down counter/timer. It is the count-down counterpart to the existing 4-bit up counters in the counters library.
- Counts from a programmable reload value to zero, then flags terminal count.
- Two modes: one-shot (stops at zero, reports done) and periodic (auto-reloads, producing a tc pulse every reload+1 cycles).
- Used as a tick generator or timeout timer beside the up counters.

Parameters:
- WIDTH, 4, counter and reload-value width in bits (legal range 2..32).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 clears all state immediately, independent of clk.
- load  input  1  when high at an edge, capture load_val into both the reload register and q.
- load_val  input  WIDTH  value captured on load.
- start  input  1  begin counting from the reload register. Honoured only in IDLE or DONE.
- stop  input  1  abort counting and return to IDLE. q holds its value.
- periodic  input  1  mode select, sampled only on the edge that accepts start. 1 = periodic, 0 = one-shot.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, high for exactly one cycle per expiry.
- busy  output  1  high while state is RUN.
- done  output  1  high while state is DONE (one-shot expired).

Behaviour:
- Reset (rst=0): q=0, reload=0, mode=one-shot, state=IDLE, tc=0, busy=0, done=0. Applied asynchronously; takes effect even mid-RUN.
- States:
  - IDLE: q holds.
  - RUN: counting.
  - DONE: q holds at 0.
- Edge priority, highest first: load > stop > start > count.
- load (any state): reload<=load_val, q<=load_val. State is unchanged, so a load in RUN restarts the count from the new value. tc=0 that cycle.
- stop (RUN only, no load): state<=IDLE, q holds. Ignored in IDLE and DONE.
- start (IDLE or DONE, no load or stop): q<=reload, mode<=periodic, state<=RUN. start while in RUN is ignored and mode does not change.
- Counting in RUN:
  - q!=0: q<=q-1.
  - q==0, one-shot: state<=DONE, q stays 0, tc<=1.
  - q==0, periodic: q<=reload, tc<=1, stays RUN.
- Period: reload+1 cycles from the first RUN cycle to the tc pulse.
  - reload=0 in periodic mode: tc is high every cycle and q stays 0.
  - reload=0 in one-shot mode: tc fires 1 cycle after start.
- Arithmetic: WIDTH-bit unsigned. q never underflows, because it wraps only via reload, never 0->all-ones.
- tc is high only on the single cycle following a zero-expiry edge. It is cleared by any other edge, including load or stop.
- busy and done are decoded from registered state; no combinational path from inputs to outputs.
- Simultaneous load+start: load wins and start is dropped. The user asserts start on a later cycle.

Decomposition:
- Shared package file counters_pkg holds:
  - state encodings as localparams: ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10;
  - default WIDTH constant.
- Encoding 2'b11 is illegal and recovers to ST_IDLE.
- One natural sub-module, down_counter_core:
  - a WIDTH-bit register with load, decrement-enable and the same async active-low reset;
  - outputs q and a zero flag.
- The top level holds the FSM, the reload register, the mode bit and tc.

Test Plan (WIDTH=4):
- Reset in mid-RUN: q=9, drive rst=0 between clock edges -> q=0, busy=0, done=0, tc=0 before the next edge. After rst=1 the block stays idle.
- One-shot: load 5, then start(periodic=0) -> q: 5,4,3,2,1,0; on the next edge done=1, busy=0, tc=1 for one cycle. q then holds 0 and done stays 1 until start.
- Periodic: load 3, start(periodic=1) -> q: 3,2,1,0,3,2,1,0... with tc high one cycle after every 0. Four cycles between tc pulses.
- Edge values:
  - load 15, one-shot -> 16 RUN cycles before done, no wrap past 0;
  - load 0, periodic -> tc held high every cycle, q=0 constant.
- Stop/resume: during periodic load 7, assert stop when q=2 -> IDLE, q holds 2, tc=0. Then start -> q=7 and counting resumes.
- Priority:
  - load=1 and stop=1 on the same edge in RUN -> q=load_val, state stays RUN;
  - start in RUN -> ignored, and a changed periodic input does not alter the mode.

Source files
------------

// File: rtl/counters_pkg.sv
// Shared definitions for the counters library.
// Holds the FSM state encodings used by the down counter and the default
// counter width. The encoding 2'b11 is unused; the FSM steers it to idle.
package counters_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // A new count may only be launched from a resting state.
  function automatic logic start_allowed(input logic [1:0] st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/down_counter_load_if.sv
// Control/status bundle of the loadable down counter.
//   master drives : load, load_val, start, stop, periodic
//   slave  drives : q (current count), tc (terminal-count pulse),
//                   busy (counting), done (one-shot expired)
interface down_counter_load_if
  import counters_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, stop, periodic,
    input  q, tc, busy, done
  );

  modport slave (
    input  load, load_val, start, stop, periodic,
    output q, tc, busy, done
  );

endinterface

// File: rtl/down_counter_core.sv
// WIDTH-bit count register with parallel load and decrement enable.
// Ports: clk, rst (async active-low), i_load/i_load_val (capture value),
//        i_dec (decrement one step), o_q (count), o_zero (count is zero).
// A decrement request at zero is ignored, so the register never wraps
// from 0 to all-ones; only a load brings it back up.
module down_counter_core
  import counters_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_q,
  output logic             o_zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_dec && (r_q != '0)) begin
      r_q <= r_q - ONE;
    end
  end

  assign o_q    = r_q;
  assign o_zero = (r_q == '0);

endmodule

// File: rtl/down_counter_load.sv
// Loadable down counter / timer with one-shot and periodic modes.
// Ports: clk, rst (async active-low), bus (down_counter_load_if.slave):
//   load/load_val capture a new reload value and count, start launches a
//   count from the reload value, stop aborts to idle, periodic selects the
//   mode at start; q, tc, busy and done report status.
// Per-edge priority: load > stop > start > count.
module down_counter_load
  import counters_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  down_counter_load_if.slave   bus
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_reload;
  logic             r_mode;   // 1 = periodic, 0 = one-shot
  logic             r_tc;

  logic             w_core_load;
  logic [WIDTH-1:0] w_core_val;
  logic             w_core_dec;
  logic [WIDTH-1:0] w_q;
  logic             w_zero;

  // Steering of the count register for this edge.
  always_comb begin
    w_core_load = 1'b0;
    w_core_val  = r_reload;
    w_core_dec  = 1'b0;
    if (bus.load) begin
      w_core_load = 1'b1;
      w_core_val  = bus.load_val;
    end else if (bus.stop && (r_state == ST_RUN)) begin
      w_core_load = 1'b0;          // abort: q holds
    end else if (bus.start && start_allowed(r_state)) begin
      w_core_load = 1'b1;          // relaunch from reload value
    end else if (r_state == ST_RUN) begin
      if (!w_zero) begin
        w_core_dec = 1'b1;
      end else if (r_mode) begin
        w_core_load = 1'b1;        // periodic expiry reloads
      end else begin
        w_core_load = 1'b0;        // one-shot expiry: q stays 0
      end
    end else begin
      w_core_load = 1'b0;
    end
  end

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_core_load),
    .i_load_val (w_core_val),
    .i_dec      (w_core_dec),
    .o_q        (w_q),
    .o_zero     (w_zero)
  );

  // Control FSM, reload register, mode bit and terminal-count pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;                // tc lasts one cycle only
      if (bus.load) begin
        r_reload <= bus.load_val;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (!bus.load && bus.start) begin
            r_mode  <= bus.periodic;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.load) begin
            if (bus.stop) begin
              r_state <= ST_IDLE;
            end else if (w_zero) begin
              r_tc <= 1'b1;
              if (!r_mode) begin
                r_state <= ST_DONE;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.q    = w_q;
  assign bus.tc   = r_tc;
  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);

endmodule
